dsm_read_ctrl: RTL and testbench

Conversion sequencer for the flash bit-line delta-sigma sense modulator. Accepts read requests carrying a charge trim and a decision threshold, applies the trim, runs the modulator enable for a fixed decision window, captures its 9-bit injection count, and returns the count plus a one-bit cell decision over a valid/ready handshake. Sits between the flash read state machine and one `dsm` instance; it is the only driver of the modulator's `en` and `chrg_trim`.

---
 rtl/dsm_ctrl_pkg.sv | 23 ++
 rtl/dsm_window_timer.sv | 35 +++
 rtl/dsm_read_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dsm_read_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_ctrl_pkg.sv
// ============================================================================
// Module      : dsm_ctrl_pkg
// Description : Shared types and widths for the delta-sigma read controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsm_ctrl_pkg;

    localparam int DSM_CNT_W  = 9;
    localparam int DSM_TRIM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CONV   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } dsm_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/dsm_window_timer.sv
// ============================================================================
// Module      : dsm_window_timer
// Description : Loadable down-counter; done is high while the count is 1,
//               marking the final cycle of a loaded duration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsm_window_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign done = (r_cnt == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/dsm_read_ctrl.sv
// ============================================================================
// Module      : dsm_read_ctrl
// Description : Conversion sequencer for the bit-line delta-sigma modulator.
//               Optional macro DSM_READ_CTRL_AVG_EN: average 2^NCONV_LOG2
//               conversions per request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsm_read_ctrl
    import dsm_ctrl_pkg::*;
#(
    parameter int WINDOW     = 256,
    parameter int SETTLE     = 4,
    parameter int NCONV_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DSM_TRIM_W-1:0] req_trim,
    input  logic [DSM_CNT_W-1:0]  req_thresh,
    input  logic                  abort,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DSM_CNT_W-1:0]  rsp_count,
    output logic                  rsp_bit,
    output logic                  busy,
    output logic                  dsm_en,
    output logic [DSM_TRIM_W-1:0] dsm_chrg_trim,
    input  logic [DSM_CNT_W-1:0]  dsm_out
);

`ifdef DSM_READ_CTRL_AVG_EN
    localparam int c_LOG2 = NCONV_LOG2;
`else
    // Single conversion per request; NCONV_LOG2 has no effect in this build.
    localparam int c_LOG2 = 0 * NCONV_LOG2;
`endif
    localparam int c_ACC_W = DSM_CNT_W + c_LOG2;
    localparam int c_IDX_W = (c_LOG2 > 0) ? c_LOG2 : 1;
    localparam int c_TMR_W = 10;
    localparam logic [c_TMR_W-1:0] c_SETTLE_LEN = c_TMR_W'(SETTLE);
    localparam logic [c_TMR_W-1:0] c_CONV_LEN   = c_TMR_W'(WINDOW + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'((1 << c_LOG2) - 1);

    dsm_rd_state_t         r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DSM_CNT_W-1:0]  r_rsp_count;
    logic                  r_rsp_bit;
    logic                  r_busy;
    logic                  r_dsm_en;
    logic [DSM_TRIM_W-1:0] r_trim;
    logic [DSM_CNT_W-1:0]  r_thresh;
    logic [c_ACC_W-1:0]    r_acc;
    logic [c_IDX_W-1:0]    r_conv_idx;

    logic                  w_tmr_load;
    logic [c_TMR_W-1:0]    w_tmr_val;
    logic                  w_tmr_done;
    logic [DSM_CNT_W-1:0]  w_avg;

    assign w_avg = r_acc[c_ACC_W-1:c_LOG2];

    // Timer is loaded on entry to SETTLE and on every entry to CONV.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_CONV_LEN;
        case (r_state)
            ST_IDLE: begin
                w_tmr_load = req_valid;
                w_tmr_val  = c_SETTLE_LEN;
            end
            ST_SETTLE: w_tmr_load = w_tmr_done;
            ST_GAP:    w_tmr_load = 1'b1;
            default:   w_tmr_load = 1'b0;
        endcase
    end

    dsm_window_timer #(
        .WIDTH    (c_TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_count <= '0;
            r_rsp_bit   <= 1'b0;
            r_busy      <= 1'b0;
            r_dsm_en    <= 1'b0;
            r_trim      <= '0;
            r_thresh    <= '0;
            r_acc       <= '0;
            r_conv_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state     <= ST_SETTLE;
                        r_trim      <= req_trim;
                        r_thresh    <= req_thresh;
                        r_acc       <= '0;
                        r_conv_idx  <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SETTLE, ST_CONV, ST_GAP: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_dsm_en    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else if (r_state == ST_GAP ||
                                 (r_state == ST_SETTLE && w_tmr_done)) begin
                        r_state  <= ST_CONV;
                        r_dsm_en <= 1'b1;
                    end else if (r_state == ST_CONV && w_tmr_done) begin
                        // dsm_out now holds exactly WINDOW decisions.
                        r_acc    <= r_acc + c_ACC_W'(dsm_out);
                        r_dsm_en <= 1'b0;
                        if (r_conv_idx == c_LAST_IDX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state    <= ST_GAP;
                            r_conv_idx <= r_conv_idx + c_IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_count <= w_avg;
                        r_rsp_bit   <= (w_avg < r_thresh);
                    end else if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_count     = r_rsp_count;
    assign rsp_bit       = r_rsp_bit;
    assign busy          = r_busy;
    assign dsm_en        = r_dsm_en;
    assign dsm_chrg_trim = r_trim;

endmodule

`default_nettype wire

// File: tb/tb_dsm_read_ctrl.sv
// ============================================================================
// Module      : tb_dsm_read_ctrl
// Description : Directed self-checking bench for dsm_read_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsm_read_ctrl;

`ifdef DSM_READ_CTRL_AVG_EN
    localparam int A_LAT = 262 + 3 * 258;
    localparam int B_LAT = 514 + 3 * 513;
`else
    localparam int A_LAT = 262;
    localparam int B_LAT = 514;
`endif
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_trim;
    logic [8:0] req_thresh;
    logic       a_req_valid, a_req_ready, a_abort, a_rsp_valid, a_rsp_ready;
    logic [8:0] a_rsp_count, a_dsm_out;
    logic       a_rsp_bit, a_busy, a_dsm_en;
    logic [7:0] a_trim_o;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [8:0] b_rsp_count, b_dsm_out;
    logic       b_rsp_bit, b_busy, b_dsm_en;
    logic [7:0] b_trim_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dsm_read_ctrl #(.WINDOW(256), .SETTLE(4), .NCONV_LOG2(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_trim(req_trim), .req_thresh(req_thresh), .abort(a_abort),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_count(a_rsp_count),
        .rsp_bit(a_rsp_bit), .busy(a_busy), .dsm_en(a_dsm_en),
        .dsm_chrg_trim(a_trim_o), .dsm_out(a_dsm_out)
    );

    dsm_read_ctrl #(.WINDOW(511), .SETTLE(1), .NCONV_LOG2(2)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_trim(req_trim), .req_thresh(req_thresh), .abort(1'b0),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_count(b_rsp_count),
        .rsp_bit(b_rsp_bit), .busy(b_busy), .dsm_en(b_dsm_en),
        .dsm_chrg_trim(b_trim_o), .dsm_out(b_dsm_out)
    );

    // Modulator models: count one per enabled cycle, clear when disabled.
    logic [8:0] a_cnt, b_cnt, a_fixed;
    logic       a_en_q, a_fixed_mode;
    int         a_rises = 0;
    int         a_base;

    always @(posedge clk) begin
        a_cnt  <= a_dsm_en ? a_cnt + 9'd1 : 9'd0;
        b_cnt  <= b_dsm_en ? b_cnt + 9'd1 : 9'd0;
        a_en_q <= a_dsm_en;
        if (a_dsm_en && !a_en_q) a_rises <= a_rises + 1;
    end

    assign a_fixed   = 9'(200 + ((a_rises - a_base - 1) & 3));
    assign a_dsm_out = a_fixed_mode ? a_fixed : a_cnt;
    assign b_dsm_out = b_cnt;

    task automatic send_a(input logic [7:0] trim, input logic [8:0] thr);
        req_trim    = trim;
        req_thresh  = thr;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!a_rsp_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack_a();
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1 a_rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_rsp_valid, a_rsp_count, a_rsp_bit, a_busy, a_dsm_en, a_trim_o} !== {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b cnt=%0d bit=%b busy=%b en=%b trim=%h required 1 0 0 0 0 0 00",
                     a_req_ready, a_rsp_valid, a_rsp_count, a_rsp_bit, a_busy, a_dsm_en, a_trim_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        send_a(8'h40, 9'd100);
        checks++;
        if ({a_busy, a_req_ready, a_trim_o, a_dsm_en} !== {1'b1, 1'b0, 8'h40, 1'b0}) begin
            errors++;
            $display("FAIL accept_state: got busy=%b rdy=%b trim=%h en=%b required 1 0 40 0", a_busy, a_req_ready, a_trim_o, a_dsm_en);
        end
        wait_a(n);
        checks++;
        if (n !== A_LAT) begin errors++; $display("FAIL single_latency: got %0d required %0d", n, A_LAT); end
        checks++;
        if (a_rsp_count !== 9'd256) begin errors++; $display("FAIL single_count: got %0d required 256", a_rsp_count); end
        checks++;
        if (a_rsp_bit !== 1'b0) begin errors++; $display("FAIL single_bit: got %b required 0", a_rsp_bit); end
        ack_a();
        checks++;
        if ({a_rsp_valid, a_req_ready, a_busy, a_trim_o} !== {1'b0, 1'b1, 1'b0, 8'h40}) begin
            errors++;
            $display("FAIL after_ack: got vld=%b rdy=%b busy=%b trim=%h required 0 1 0 40", a_rsp_valid, a_req_ready, a_busy, a_trim_o);
        end
    endtask

    task automatic test_hold();
        int n;
        send_a(8'h40, 9'd300);
        wait_a(n);
        checks++;
        if (a_rsp_bit !== 1'b1) begin errors++; $display("FAIL hold_bit: got %b required 1", a_rsp_bit); end
        for (int i = 0; i < 10; i++) begin
            a_abort = (i == 3);
            @(negedge clk);
            checks++;
            if ({a_rsp_valid, a_req_ready, a_rsp_count, a_rsp_bit} !== {1'b1, 1'b0, 9'd256, 1'b1}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b cnt=%0d bit=%b required 1 0 256 1", i, a_rsp_valid, a_req_ready, a_rsp_count, a_rsp_bit);
            end
        end
        a_abort = 1'b0;
        ack_a();
    endtask

    task automatic test_back_to_back();
        int n;
        send_a(8'h11, 9'd257);
        wait_a(n);
        checks++;
        if (a_rsp_bit !== 1'b1) begin errors++; $display("FAIL b2b_bit_257: got %b required 1", a_rsp_bit); end
        ack_a();
        checks++;
        if (a_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", a_req_ready); end
        send_a(8'h22, 9'd256);
        checks++;
        if ({a_busy, a_trim_o} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b trim=%h required 1 22", a_busy, a_trim_o);
        end
        wait_a(n);
        checks++;
        if ({n, a_rsp_count, a_rsp_bit} !== {A_LAT, 9'd256, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d cnt=%0d bit=%b required %0d 256 0", n, a_rsp_count, a_rsp_bit, A_LAT);
        end
        ack_a();
    endtask

    task automatic test_abort();
        int n;
        int seen;
        send_a(8'h33, 9'd100);
        n = 0;
        while (!a_dsm_en && n < 20) begin @(negedge clk); n++; end
        repeat (49) @(negedge clk);
        a_abort = 1'b1;
        @(posedge clk);
        #1 a_abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_busy, a_dsm_en, a_req_ready, a_rsp_valid} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b en=%b rdy=%b vld=%b required 0 0 1 0", a_busy, a_dsm_en, a_req_ready, a_rsp_valid);
        end
        seen = 0;
        repeat (300) begin @(negedge clk); if (a_rsp_valid || a_dsm_en) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp: got %0d active cycles required 0", seen); end
        send_a(8'h44, 9'd100);
        wait_a(n);
        checks++;
        if ({n, a_rsp_count} !== {A_LAT, 9'd256}) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d cnt=%0d required %0d 256", n, a_rsp_count, A_LAT);
        end
        ack_a();
    endtask

    task automatic test_reset_mid_conv();
        int n;
        int seen;
        send_a(8'h55, 9'd100);
        n = 0;
        while (!a_dsm_en && n < 20) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_rsp_valid, a_rsp_count, a_rsp_bit, a_busy, a_dsm_en, a_trim_o} !== {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_mid_conv: got rdy=%b vld=%b cnt=%0d bit=%b busy=%b en=%b trim=%h required 1 0 0 0 0 0 00",
                     a_req_ready, a_rsp_valid, a_rsp_count, a_rsp_bit, a_busy, a_dsm_en, a_trim_o);
        end
        seen = 0;
        repeat (300) begin @(negedge clk); if (a_rsp_valid || a_busy) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_no_rsp: got %0d active cycles required 0", seen); end
    endtask

    task automatic test_wide_window();
        int n;
        req_trim    = 8'hA5;
        req_thresh  = 9'd511;
        b_req_valid = 1'b1;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!b_rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
        checks++;
        if (n !== B_LAT) begin errors++; $display("FAIL wide_latency: got %0d required %0d", n, B_LAT); end
        checks++;
        if ({b_rsp_count, b_rsp_bit, b_trim_o} !== {9'd511, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL wide_count: got cnt=%0d bit=%b trim=%h required 511 0 a5", b_rsp_count, b_rsp_bit, b_trim_o);
        end
        b_rsp_ready = 1'b1;
        @(posedge clk);
        #1 b_rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_rsp_valid, b_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL wide_ack: got vld=%b rdy=%b required 0 1", b_rsp_valid, b_req_ready);
        end
    endtask

`ifdef DSM_READ_CTRL_AVG_EN
    task automatic test_average();
        int n;
        a_base       = a_rises;
        a_fixed_mode = 1'b1;
        send_a(8'h66, 9'd202);
        wait_a(n);
        checks++;
        if ({a_rsp_count, a_rsp_bit} !== {9'd201, 1'b1}) begin
            errors++;
            $display("FAIL avg_count: got cnt=%0d bit=%b required 201 1", a_rsp_count, a_rsp_bit);
        end
        checks++;
        if (a_rises - a_base !== 4) begin errors++; $display("FAIL avg_windows: got %0d required 4", a_rises - a_base); end
        ack_a();
        a_fixed_mode = 1'b0;
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        req_trim     = '0;
        req_thresh   = '0;
        a_req_valid  = 1'b0;
        a_abort      = 1'b0;
        a_rsp_ready  = 1'b0;
        b_req_valid  = 1'b0;
        b_rsp_ready  = 1'b0;
        a_fixed_mode = 1'b0;
        a_base       = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_abort();
        test_reset_mid_conv();
        test_wide_window();
`ifdef DSM_READ_CTRL_AVG_EN
        test_average();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
